lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Parametrised load/store unit that replaces the fixed single-cycle memory path of the two-stage core (store-data generator plus load writeback) with a variable-latency memory handshake. It accepts one load/store per pipeline slot from execute, stalls the pipeline while the access is outstanding, generates byte-lane write masks and aligned store data, and extracts and extends load data into a registered writeback to the register file. It supports RV32 and RV64, flags misaligned or illegal accesses, and never touches memory for them.

Parameters:
RV64, 0, 1 = 64-bit datapath (DW=64, doubleword and WU ops legal); 0 = DW=32
ADDR_WIDTH, 32, width of the effective address from execute
MEM_ADDR_WIDTH, 12, memory word-index width; OFF = RV64 ? 3 : 2 low address bits dropped

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iReqVld  in  1  execute presents a memory instruction
iLoad  in  1  instruction is a load
iStore  in  1  instruction is a store (iLoad & iStore never both 1)
iFunct3  in  3  0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU
iAddr  in  ADDR_WIDTH  effective address
iStoreDat  in  DW  rs2 value, data in LSBs
iRd  in  5  load destination register
oStall  out  1  hold fetch/decode/execute
oMisalign  out  1  misaligned or illegal-size access rejected
oMemEn  out  1  memory request valid
oMemWrEn  out  1  request is a write
oMemAddr  out  MEM_ADDR_WIDTH  word index = latched iAddr[MEM_ADDR_WIDTH+OFF-1:OFF]
oMemWrMask  out  DW  bit mask, all 8 bits of each written byte lane = 1
oMemWrDat  out  DW  store data shifted into its byte lane
iMemGnt  in  1  memory accepts request this cycle
iMemRspVld  in  1  load data valid
iMemDat  in  DW  load data (full word)
oRfWrEn  out  1  register-file write
oRfWrAddr  out  5  destination register
oRfWrDat  out  DW  extended load result

Behaviour:
- FSM states: IDLE, REQ, RSP, WB. Reset (any state, any cycle) -> IDLE; all registered outputs and latched fields cleared to 0.
- Legal: size D, and funct3 6 (WU), only when RV64=1; funct3 7 never legal. Aligned: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
- IDLE: accept = iReqVld & (iLoad|iStore) & legal & aligned. On accept, latch addr, size, signedness, load/store, rd, and the shifted data/mask, then go to REQ. If iReqVld & (iLoad|iStore) & ~(legal & aligned): oMisalign=1 combinationally that cycle, no state change, oStall=0.
- REQ: oMemEn=1, oMemWrEn=store, oMemAddr/oMemWrMask/oMemWrDat from latches, held stable until iMemGnt. On gnt, a store goes to IDLE and a load goes to RSP. For loads, oMemWrMask and oMemWrDat are 0.
- RSP: oMemEn=0. On iMemRspVld, select the byte lane addr[OFF-1:0] from iMemDat, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to DW. Register the result into oRfWrDat and go to WB. On RV32, W passes through unchanged.
- WB: oRfWrEn=1 for exactly one cycle if rd!=0 (rd=0 gives oRfWrEn=0, data still driven). Then go to IDLE.
- oStall (combinational) = (IDLE & accept) | (REQ & ~(store & iMemGnt)) | RSP. It is 0 in the store-grant cycle and in WB, so the pipeline advances exactly once per instruction.
- Latency: store with immediate gnt takes 2 cycles. Load with immediate gnt and a next-cycle response writes back 3 cycles after accept.
- While busy (not IDLE), iReqVld and the other request inputs are ignored.
- iMemRspVld outside RSP is ignored (covers a stale response after reset). iMemGnt outside REQ is ignored.
- Outputs not named for a state are 0 in that state.

Test Plan:
- RV64=0, store W addr 0x104, data 0xDEADBEEF, gnt on 1st REQ cycle -> oMemAddr=0x041, mask 0xFFFFFFFF, wrDat 0xDEADBEEF; oStall 1 then 0; back to IDLE after 2 cycles.
- RV64=0, store B addr 0x203, data 0x5A, gnt delayed 3 cycles -> mask 0xFF000000, wrDat 0x5A000000, both stable for all 4 REQ cycles; oStall stays high until the gnt cycle.
- RV64=0, LB addr 0x102 rd=5, iMemDat 0x00800000 -> oRfWrDat 0xFFFFFF80, oRfWrEn=1 for 1 cycle; LBU of the same access -> 0x00000080.
- RV64=1, LD addr 0x18 and LWU addr 0x1C with iMemDat 0x8000000112345678 -> oMemAddr=0x003; LD gives 0x8000000112345678, LWU gives 0x0000000080000001.
- LH addr 0x101 -> oMisalign=1, oMemEn stays 0, oStall=0. RV64=0 with funct3=3 -> oMisalign=1. Load with rd=0 -> oRfWrEn=0.
- rst asserted in RSP, then iMemRspVld=1 the next cycle -> stays IDLE, oRfWrEn=0, all outputs 0; the next accepted store proceeds normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit with a variable-latency memory handshake.
// It accepts one load or store from execute and holds the pipeline
// until the access completes. Stores are sent as lane-aligned data
// with a per-bit write mask. Load results are lane-selected,
// sign- or zero-extended, and registered for register-file writeback.
//
// Request handshake: while oMemEn is 1, the request (oMemWrEn,
// oMemAddr, oMemWrMask, oMemWrDat) is held stable. The request
// transfers in the cycle that oMemEn and iMemGnt are both 1. For a
// load, load data transfers in the first cycle after the grant in
// which iMemRspVld is 1.
module lsu_mem_ctrl #(
  parameter int RV64           = 0,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 12,
  localparam int DW            = (RV64 != 0) ? 64 : 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iReqVld,
  input  logic                      iLoad,
  input  logic                      iStore,
  input  logic [2:0]                iFunct3,
  input  logic [ADDR_WIDTH-1:0]     iAddr,
  input  logic [DW-1:0]             iStoreDat,
  input  logic [4:0]                iRd,
  output logic                      oStall,
  output logic                      oMisalign,
  output logic                      oMemEn,
  output logic                      oMemWrEn,
  output logic [MEM_ADDR_WIDTH-1:0] oMemAddr,
  output logic [DW-1:0]             oMemWrMask,
  output logic [DW-1:0]             oMemWrDat,
  input  logic                      iMemGnt,
  input  logic                      iMemRspVld,
  input  logic [DW-1:0]             iMemDat,
  output logic                      oRfWrEn,
  output logic [4:0]                oRfWrAddr,
  output logic [DW-1:0]             oRfWrDat
);
  localparam int OFF = (RV64 != 0) ? 3 : 2;
  localparam int NB  = DW / 8;

  typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

  state_t                    state;
  logic [MEM_ADDR_WIDTH-1:0] maddr_q;
  logic [OFF-1:0]            lane_q;
  logic [1:0]                size_q;
  logic                      uns_q;
  logic                      store_q;
  logic [4:0]                rd_q;
  logic [DW-1:0]             mask_q;
  logic [DW-1:0]             wdat_q;
  logic [DW-1:0]             rdat_q;

  logic            legal;
  logic            aligned;
  logic            mem_op;
  logic            accept;
  logic [OFF-1:0]  lane_in;
  logic [NB-1:0]   be_base;
  logic [NB-1:0]   be_lane;
  logic [DW-1:0]   st_mask;
  logic [DW-1:0]   st_dat;
  logic [DW-1:0]   shifted;
  logic [DW-1:0]   keep;
  logic            sign_bit;
  logic            fill;
  logic [DW-1:0]   ld_res;

  // Upper address bits above the word index are intentionally unused.
  logic unused_addr;
  assign unused_addr = ^iAddr;

  assign lane_in = iAddr[OFF-1:0];
  assign mem_op  = iReqVld & (iLoad | iStore);
  assign accept  = (state == IDLE) & mem_op & legal & aligned;

  // Decode access legality and natural alignment from funct3 and the address.
  always_comb begin
    legal = 1'b1;
    case (iFunct3)
      3'd3, 3'd6: legal = (RV64 != 0);
      3'd7:       legal = 1'b0;
      default:    legal = 1'b1;
    endcase
    aligned = 1'b1;
    case (iFunct3[1:0])
      2'd1:    aligned = ~iAddr[0];
      2'd2:    aligned = (iAddr[1:0] == 2'b00);
      2'd3:    aligned = (iAddr[2:0] == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  // Build the store byte enables, the per-bit mask, and the lane-shifted data.
  always_comb begin
    case (iFunct3[1:0])
      2'd0:    be_base = NB'(1);
      2'd1:    be_base = NB'(3);
      2'd2:    be_base = NB'(15);
      default: be_base = NB'(255);
    endcase
    be_lane = be_base << lane_in;
    st_mask = '0;
    for (int i = 0; i < NB; i++) begin
      st_mask[8*i +: 8] = {8{be_lane[i]}};
    end
    st_dat = iStoreDat << {lane_in, 3'b000};
  end

  // Select the addressed lane from the memory word and extend it to DW.
  always_comb begin
    shifted = iMemDat >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    begin keep = DW'(8'hFF);         sign_bit = shifted[7];    end
      2'd1:    begin keep = DW'(16'hFFFF);      sign_bit = shifted[15];   end
      2'd2:    begin keep = DW'(32'hFFFF_FFFF); sign_bit = shifted[31];   end
      default: begin keep = '1;                 sign_bit = shifted[DW-1]; end
    endcase
    fill   = ~uns_q & sign_bit;
    ld_res = (shifted & keep) | (~keep & {DW{fill}});
  end

  // Access FSM: latch the request on accept, hold it until granted, then capture the load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      maddr_q <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      rd_q    <= '0;
      mask_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            maddr_q <= iAddr[MEM_ADDR_WIDTH+OFF-1:OFF];
            lane_q  <= lane_in;
            size_q  <= iFunct3[1:0];
            uns_q   <= iFunct3[2];
            store_q <= iStore;
            rd_q    <= iRd;
            mask_q  <= iStore ? st_mask : '0;
            wdat_q  <= iStore ? st_dat : '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (iMemGnt) state <= store_q ? IDLE : RSP;
        end
        RSP: begin
          if (iMemRspVld) begin
            rdat_q <= ld_res;
            state  <= WB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oMemEn     = (state == REQ);
  assign oMemWrEn   = (state == REQ) & store_q;
  assign oMemAddr   = (state == REQ) ? maddr_q : '0;
  assign oMemWrMask = (state == REQ) ? mask_q : '0;
  assign oMemWrDat  = (state == REQ) ? wdat_q : '0;
  assign oRfWrEn    = (state == WB) & (rd_q != 5'd0);
  assign oRfWrAddr  = (state == WB) ? rd_q : '0;
  assign oRfWrDat   = (state == WB) ? rdat_q : '0;
  assign oMisalign  = (state == IDLE) & mem_op & ~(legal & aligned);
  assign oStall     = accept | ((state == REQ) & ~(store_q & iMemGnt)) | (state == RSP);
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl. It drives an RV32 instance and an RV64
// instance from shared stimulus, and 'sel' picks which instance is
// active. Expected memory requests and writebacks go into queues, and
// a negedge monitor compares them against the active instance.
module tb_lsu_mem_ctrl;
  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_vld;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [63:0] store_dat;
  logic [4:0]  rd;
  logic        mem_gnt;
  logic        mem_rsp_vld;
  logic [63:0] mem_dat;

  logic        a_stall, a_mis, a_en, a_we, a_rfen;
  logic [11:0] a_addr;
  logic [31:0] a_mask, a_dat, a_rfd;
  logic [4:0]  a_rfa;
  logic        b_stall, b_mis, b_en, b_we, b_rfen;
  logic [11:0] b_addr;
  logic [63:0] b_mask, b_dat, b_rfd;
  logic [4:0]  b_rfa;

  logic        m_stall, m_mis, m_en, m_we, m_rfen;
  logic [11:0] m_addr;
  logic [63:0] m_mask, m_dat, m_rfd;
  logic [4:0]  m_rfa;

  int n_checks = 0;
  int n_fail   = 0;

  logic [140:0] exp_req_q[$];
  logic [68:0]  exp_wb_q[$];

  lsu_mem_ctrl #(.RV64(0)) u32 (
    .clk(clk), .rst(rst), .iReqVld(req_vld & ~sel), .iLoad(load), .iStore(store),
    .iFunct3(funct3), .iAddr(addr), .iStoreDat(store_dat[31:0]), .iRd(rd),
    .oStall(a_stall), .oMisalign(a_mis), .oMemEn(a_en), .oMemWrEn(a_we),
    .oMemAddr(a_addr), .oMemWrMask(a_mask), .oMemWrDat(a_dat),
    .iMemGnt(mem_gnt), .iMemRspVld(mem_rsp_vld), .iMemDat(mem_dat[31:0]),
    .oRfWrEn(a_rfen), .oRfWrAddr(a_rfa), .oRfWrDat(a_rfd)
  );

  lsu_mem_ctrl #(.RV64(1)) u64 (
    .clk(clk), .rst(rst), .iReqVld(req_vld & sel), .iLoad(load), .iStore(store),
    .iFunct3(funct3), .iAddr(addr), .iStoreDat(store_dat), .iRd(rd),
    .oStall(b_stall), .oMisalign(b_mis), .oMemEn(b_en), .oMemWrEn(b_we),
    .oMemAddr(b_addr), .oMemWrMask(b_mask), .oMemWrDat(b_dat),
    .iMemGnt(mem_gnt), .iMemRspVld(mem_rsp_vld), .iMemDat(mem_dat),
    .oRfWrEn(b_rfen), .oRfWrAddr(b_rfa), .oRfWrDat(b_rfd)
  );

  assign m_stall = sel ? b_stall : a_stall;
  assign m_mis   = sel ? b_mis : a_mis;
  assign m_en    = sel ? b_en : a_en;
  assign m_we    = sel ? b_we : a_we;
  assign m_addr  = sel ? b_addr : a_addr;
  assign m_mask  = sel ? b_mask : {32'b0, a_mask};
  assign m_dat   = sel ? b_dat : {32'b0, a_dat};
  assign m_rfen  = sel ? b_rfen : a_rfen;
  assign m_rfa   = sel ? b_rfa : a_rfa;
  assign m_rfd   = sel ? b_rfd : {32'b0, a_rfd};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic we, input logic [11:0] a, input logic [63:0] mask,
                          input logic [63:0] dat);
    exp_req_q.push_back({we, a, mask, dat});
  endtask

  task automatic push_wb(input logic [4:0] r, input logic [63:0] dat);
    exp_wb_q.push_back({r, dat});
  endtask

  // Scoreboard monitor: the head request must stay stable until it is
  // granted, and every register-file write must match the next expected writeback.
  always @(negedge clk) begin
    if (m_en) begin
      if (exp_req_q.size() == 0) begin
        check("unexpected_mem_req", 64'(m_en), 64'd0);
      end else begin
        check("req_we",   64'(m_we),   64'(exp_req_q[0][140]));
        check("req_addr", 64'(m_addr), 64'(exp_req_q[0][139:128]));
        check("req_mask", m_mask,      exp_req_q[0][127:64]);
        check("req_dat",  m_dat,       exp_req_q[0][63:0]);
        if (mem_gnt) void'(exp_req_q.pop_front());
      end
    end
    if (m_rfen) begin
      if (exp_wb_q.size() == 0) begin
        check("unexpected_rf_wr", 64'(m_rfen), 64'd0);
      end else begin
        check("wb_rd",  64'(m_rfa), 64'(exp_wb_q[0][68:64]));
        check("wb_dat", m_rfd,      exp_wb_q[0][63:0]);
        void'(exp_wb_q.pop_front());
      end
    end
  end

  // Driver: one accepted access with a grant delay (gdly) and a response delay (rdly).
  task automatic do_access(input logic s, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [63:0] sd, input logic [4:0] r,
                           input int gdly, input int rdly, input logic [63:0] md);
    @(posedge clk); #1;
    sel = s; req_vld = 1'b1; load = ld; store = ~ld;
    funct3 = f3; addr = a; store_dat = sd; rd = r;
    #3;
    check("accept_stall", 64'(m_stall), 64'd1);
    check("accept_misalign", 64'(m_mis), 64'd0);
    @(posedge clk); #1;
    req_vld = 1'b0;
    for (int c = 0; c <= gdly; c++) begin
      mem_gnt = (c == gdly);
      mem_rsp_vld = ld;
      mem_dat = {$urandom, $urandom};
      #3;
      check("req_stall", 64'(m_stall), 64'(ld || (c != gdly)));
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0;
    mem_rsp_vld = 1'b0;
    if (ld) begin
      for (int c = 0; c <= rdly; c++) begin
        mem_rsp_vld = (c == rdly);
        mem_dat = (c == rdly) ? md : {$urandom, $urandom};
        #3;
        check("rsp_stall", 64'(m_stall), 64'd1);
        @(posedge clk); #1;
      end
      mem_rsp_vld = 1'b0;
      #3;
      check("wb_stall", 64'(m_stall), 64'd0);
    end else begin
      #3;
      check("store_done_idle", 64'(m_en), 64'd0);
    end
  endtask

  // Driver: an access that must be rejected without touching memory.
  task automatic do_reject(input logic s, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a);
    @(posedge clk); #1;
    sel = s; req_vld = 1'b1; load = ld; store = ~ld; funct3 = f3; addr = a; rd = 5'd9;
    #3;
    check("reject_misalign", 64'(m_mis), 64'd1);
    check("reject_stall", 64'(m_stall), 64'd0);
    check("reject_mem_en", 64'(m_en), 64'd0);
    @(posedge clk); #1;
    req_vld = 1'b0;
    #3;
    check("reject_stays_idle", 64'(m_en | m_stall), 64'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; req_vld = 1'b0; load = 1'b0; store = 1'b0;
    funct3 = 3'd0; addr = '0; store_dat = '0; rd = '0;
    mem_gnt = 1'b0; mem_rsp_vld = 1'b0; mem_dat = '0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_a_outputs", 64'({a_stall, a_mis, a_en, a_we, a_rfen}), 64'd0);
    check("reset_b_outputs", 64'({b_stall, b_mis, b_en, b_we, b_rfen}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // RV32 stores
    push_req(1'b1, 12'h041, 64'hFFFF_FFFF, 64'hDEAD_BEEF);
    do_access(1'b0, 1'b0, 3'd2, 32'h104, 64'hDEAD_BEEF, 5'd0, 0, 0, '0);
    push_req(1'b1, 12'h080, 64'hFF00_0000, 64'h5A00_0000);
    do_access(1'b0, 1'b0, 3'd0, 32'h203, 64'h5A, 5'd0, 3, 0, '0);
    push_req(1'b1, 12'h040, 64'hFFFF_0000, 64'hBEEF_0000);
    do_access(1'b0, 1'b0, 3'd1, 32'h102, 64'hBEEF, 5'd0, 1, 0, '0);

    // RV32 loads
    push_req(1'b0, 12'h040, 64'd0, 64'd0);
    push_wb(5'd5, 64'hFFFF_FF80);
    do_access(1'b0, 1'b1, 3'd0, 32'h102, '0, 5'd5, 0, 0, 64'h0080_0000);
    push_req(1'b0, 12'h040, 64'd0, 64'd0);
    push_wb(5'd5, 64'h0000_0080);
    do_access(1'b0, 1'b1, 3'd4, 32'h102, '0, 5'd5, 1, 2, 64'h0080_0000);
    push_req(1'b0, 12'h041, 64'd0, 64'd0);
    push_wb(5'd3, 64'hFFFF_8001);
    do_access(1'b0, 1'b1, 3'd1, 32'h106, '0, 5'd3, 0, 1, 64'h8001_0000);
    push_req(1'b0, 12'h041, 64'd0, 64'd0);
    push_wb(5'd4, 64'h0000_8001);
    do_access(1'b0, 1'b1, 3'd5, 32'h106, '0, 5'd4, 0, 0, 64'h8001_0000);
    push_req(1'b0, 12'h040, 64'd0, 64'd0);
    push_wb(5'd6, 64'h8765_4321);
    do_access(1'b0, 1'b1, 3'd2, 32'h100, '0, 5'd6, 0, 0, 64'h8765_4321);
    // Load to x0: a memory request but no register-file write
    push_req(1'b0, 12'h040, 64'd0, 64'd0);
    do_access(1'b0, 1'b1, 3'd2, 32'h100, '0, 5'd0, 0, 0, 64'h1122_3344);

    // RV64 accesses
    push_req(1'b0, 12'h003, 64'd0, 64'd0);
    push_wb(5'd10, 64'h8000_0001_1234_5678);
    do_access(1'b1, 1'b1, 3'd3, 32'h18, '0, 5'd10, 0, 0, 64'h8000_0001_1234_5678);
    push_req(1'b0, 12'h003, 64'd0, 64'd0);
    push_wb(5'd11, 64'h0000_0000_8000_0001);
    do_access(1'b1, 1'b1, 3'd6, 32'h1C, '0, 5'd11, 0, 0, 64'h8000_0001_1234_5678);
    push_req(1'b0, 12'h003, 64'd0, 64'd0);
    push_wb(5'd12, 64'hFFFF_FFFF_8000_0001);
    do_access(1'b1, 1'b1, 3'd2, 32'h1C, '0, 5'd12, 2, 0, 64'h8000_0001_1234_5678);
    push_req(1'b1, 12'h004, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF);
    do_access(1'b1, 1'b0, 3'd3, 32'h20, 64'h0123_4567_89AB_CDEF, 5'd0, 0, 0, '0);
    push_req(1'b1, 12'h004, 64'hFFFF_FFFF_0000_0000, 64'hCAFE_F00D_0000_0000);
    do_access(1'b1, 1'b0, 3'd2, 32'h24, 64'hCAFE_F00D, 5'd0, 2, 0, '0);

    // Rejected accesses
    do_reject(1'b0, 1'b1, 3'd1, 32'h101);
    do_reject(1'b0, 1'b1, 3'd3, 32'h100);
    do_reject(1'b0, 1'b1, 3'd6, 32'h100);
    do_reject(1'b1, 1'b0, 3'd7, 32'h100);
    do_reject(1'b1, 1'b1, 3'd3, 32'h1C);

    // Reset while waiting for a load response, followed by a stale response
    push_req(1'b0, 12'h040, 64'd0, 64'd0);
    @(posedge clk); #1;
    sel = 1'b0; req_vld = 1'b1; load = 1'b1; store = 1'b0;
    funct3 = 3'd2; addr = 32'h100; rd = 5'd7;
    @(posedge clk); #1;
    req_vld = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rsp_vld = 1'b1; mem_dat = 64'h0000_0000_CAFE_BABE;
    #3;
    check("post_reset_ctrl", 64'({m_stall, m_mis, m_en, m_we, m_rfen}), 64'd0);
    check("post_reset_addr", 64'(m_addr), 64'd0);
    check("post_reset_rfdat", m_rfd, 64'd0);
    @(posedge clk); #1;
    mem_rsp_vld = 1'b0;
    #3;
    check("stale_rsp_ignored", 64'({m_stall, m_rfen}), 64'd0);
    push_req(1'b1, 12'h041, 64'h0000_FF00, 64'h0000_7700);
    do_access(1'b0, 1'b0, 3'd0, 32'h105, 64'h77, 5'd0, 0, 0, '0);

    repeat (4) @(posedge clk);
    #1;
    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("wb_queue_drained", 64'(exp_wb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
